// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared state type and sizing helpers for the motion-estimation search scheduler
package me_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, FETCH, WAIT, NEXT, DONE} me_sched_state_t;

  localparam logic [31:0] SAD_MAX = 32'hFFFF_FFFF;

  function automatic int me_npos(input int macro_dim, input int search_dim);
    return search_dim - macro_dim + 1;
  endfunction

  // a lone candidate position still needs a 1-bit counter
  function automatic int me_pos_w(input int npos);
    return (npos > 1) ? $clog2(npos) : 1;
  endfunction

endpackage

// File: rtl/me_min_tracker.sv
// rtl/me_min_tracker.sv - running minimum SAD and the position that produced it
module me_min_tracker
  import me_pkg::*;
#(
  parameter int SAD_W = 16,
  parameter int POS_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad_in,
  input  logic [POS_W-1:0] cand_x,
  input  logic [POS_W-1:0] cand_y,
  output logic [SAD_W-1:0] min_sad,
  output logic [POS_W-1:0] mv_x,
  output logic [POS_W-1:0] mv_y
);

  logic [SAD_W-1:0] r_min_sad;
  logic [POS_W-1:0] r_mv_x;
  logic [POS_W-1:0] r_mv_y;

  // strict compare: on a tie the earlier raster candidate stays
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min_sad <= SAD_MAX[SAD_W-1:0];
      r_mv_x    <= '0;
      r_mv_y    <= '0;
    end else if (clear) begin
      r_min_sad <= SAD_MAX[SAD_W-1:0];
      r_mv_x    <= '0;
      r_mv_y    <= '0;
    end else if (sad_valid && (sad_in < r_min_sad)) begin
      r_min_sad <= sad_in;
      r_mv_x    <= cand_x;
      r_mv_y    <= cand_y;
    end
  end

  assign min_sad = r_min_sad;
  assign mv_x    = r_mv_x;
  assign mv_y    = r_mv_y;

endmodule

// File: rtl/me_search_sched.sv
// rtl/me_search_sched.sv - full-search SAD scheduler; ME_EARLY_EXIT_EN ends the search on a zero SAD
module me_search_sched
  import me_pkg::*;
#(
  parameter int  MACRO_DIM  = 16,
  parameter int  SEARCH_DIM = 48,
  parameter int  SAD_W      = 16,
  localparam int NPOS       = me_npos(MACRO_DIM, SEARCH_DIM),
  localparam int POS_W      = me_pos_w(NPOS),
  localparam int ROW_W      = $clog2(SEARCH_DIM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic [ROW_W-1:0] spr_row,
  output logic [POS_W-1:0] spr_col,
  output logic [ROW_W-1:0] cpr_row,
  output logic             en_spr,
  output logic             en_cpr,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad_in,
  output logic             done,
  output logic [SAD_W-1:0] min_sad,
  output logic [POS_W-1:0] mv_x,
  output logic [POS_W-1:0] mv_y
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MACRO_DIM - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NPOS - 1);

  me_sched_state_t  r_state;
  logic [POS_W-1:0] r_cand_x;
  logic [POS_W-1:0] r_cand_y;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] r_spr_row;
  logic [ROW_W-1:0] r_cpr_row;
  logic [POS_W-1:0] r_spr_col;
  logic             r_busy;
  logic             r_done;
  logic             r_en_spr;
  logic             r_en_cpr;

  logic             w_clear;
  logic             w_sad_take;
  logic             w_last_row;
  logic             w_last_x;
  logic             w_last_cand;
  logic [POS_W-1:0] w_next_x;
  logic [POS_W-1:0] w_next_y;

  assign w_clear     = (r_state == IDLE) && start;
  assign w_sad_take  = (r_state == WAIT) && sad_valid;
  assign w_last_row  = (r_row == LAST_ROW);
  assign w_last_x    = (r_cand_x == LAST_POS);
  assign w_last_cand = w_last_x && (r_cand_y == LAST_POS);
  assign w_next_x    = w_last_x ? '0 : r_cand_x + 1'b1;
  assign w_next_y    = w_last_x ? r_cand_y + 1'b1 : r_cand_y;

  // strobes and addresses are registered alongside the state, so they describe the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cand_x  <= '0;
      r_cand_y  <= '0;
      r_row     <= '0;
      r_spr_row <= '0;
      r_cpr_row <= '0;
      r_spr_col <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_en_spr  <= 1'b0;
      r_en_cpr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state   <= LOAD;
          r_busy    <= 1'b1;
          r_cand_x  <= '0;
          r_cand_y  <= '0;
          r_row     <= '0;
          r_en_cpr  <= 1'b1;
          r_cpr_row <= '0;
        end
        LOAD: if (w_last_row) begin
          r_state   <= FETCH;
          r_row     <= '0;
          r_en_cpr  <= 1'b0;
          r_cpr_row <= '0;
          r_en_spr  <= 1'b1;
          r_spr_row <= ROW_W'(r_cand_y);
          r_spr_col <= r_cand_x;
        end else begin
          r_row     <= r_row + 1'b1;
          r_cpr_row <= r_row + 1'b1;
        end
        FETCH: if (w_last_row) begin
          r_state  <= WAIT;
          r_en_spr <= 1'b0;
        end else begin
          r_row     <= r_row + 1'b1;
          r_spr_row <= ROW_W'(r_cand_y) + r_row + 1'b1;
        end
        WAIT: if (sad_valid) begin
`ifdef ME_EARLY_EXIT_EN
          if (sad_in == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else
`endif
          r_state <= NEXT;
        end
        NEXT: if (w_last_cand) begin
          r_state <= DONE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end else begin
          r_state   <= FETCH;
          r_cand_x  <= w_next_x;
          r_cand_y  <= w_next_y;
          r_row     <= '0;
          r_en_spr  <= 1'b1;
          r_spr_row <= ROW_W'(w_next_y);
          r_spr_col <= w_next_x;
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  me_min_tracker #(
    .SAD_W (SAD_W),
    .POS_W (POS_W)
  ) u_min_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_clear),
    .sad_valid (w_sad_take),
    .sad_in    (sad_in),
    .cand_x    (r_cand_x),
    .cand_y    (r_cand_y),
    .min_sad   (min_sad),
    .mv_x      (mv_x),
    .mv_y      (mv_y)
  );

  assign busy    = r_busy;
  assign done    = r_done;
  assign en_spr  = r_en_spr;
  assign en_cpr  = r_en_cpr;
  assign spr_row = r_spr_row;
  assign spr_col = r_spr_col;
  assign cpr_row = r_cpr_row;

endmodule

// File: tb/tb_me_search_sched.sv
// tb/tb_me_search_sched.sv - directed scoreboard bench for me_search_sched with a delayed-SAD datapath model
module tb_me_search_sched;

  localparam int MD = 16;
  localparam int SD = 48;
  localparam int SW = 16;
  localparam int NP = SD - MD + 1;
  localparam int PW = 6;
  localparam int RW = 6;

  typedef struct packed {
    logic [15:0] sad;
    logic [5:0]  x;
    logic [5:0]  y;
  } result_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic [RW-1:0] spr_row;
  logic [PW-1:0] spr_col;
  logic [RW-1:0] cpr_row;
  logic          en_spr;
  logic          en_cpr;
  logic          sad_valid = 1'b0;
  logic [SW-1:0] sad_in = '0;
  logic          done;
  logic [SW-1:0] min_sad;
  logic [PW-1:0] mv_x;
  logic [PW-1:0] mv_y;

  int n_cmp = 0;
  int n_fail = 0;
  int mode = 0;
  int dly_cfg = 3;

  int rows = 0, dly = 0, ex = 0, ey = 0;
  int cand_cnt = 0, spr_cycles = 0, cpr_cycles = 0, addr_err = 0, done_cnt = 0;
  logic [15:0] pend_sad = '0;

  result_t sb[$];
  bit      seen;

  me_search_sched #(.MACRO_DIM(MD), .SEARCH_DIM(SD), .SAD_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .spr_row   (spr_row),
    .spr_col   (spr_col),
    .cpr_row   (cpr_row),
    .en_spr    (en_spr),
    .en_cpr    (en_cpr),
    .sad_valid (sad_valid),
    .sad_in    (sad_in),
    .done      (done),
    .min_sad   (min_sad),
    .mv_x      (mv_x),
    .mv_y      (mv_y)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sad_of(input int x, input int y);
    case (mode)
      0:       return 16'd500;
      1:       return (x == 17 && y == 5) ? 16'd100 : 16'd200;
      2:       return ((x == 3 && y == 0) || (x == 9 && y == 20)) ? 16'd50 : 16'd200;
      default: return (x == 2 && y == 1) ? 16'd0 : 16'd300;
    endcase
  endfunction

  // datapath: returns the candidate's SAD dly_cfg cycles after its last row
  always @(negedge clk) begin
    if (!rst_n) begin
      rows = 0; dly = 0; ex = 0; ey = 0;
      cand_cnt = 0; spr_cycles = 0; cpr_cycles = 0; addr_err = 0;
      sad_valid = 1'b0;
    end else begin
      sad_valid = 1'b0;
      if (done) done_cnt++;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          sad_valid = 1'b1;
          sad_in    = pend_sad;
        end
      end
      if (en_cpr) begin
        if (cpr_row == '0) begin
          rows = 0; dly = 0; ex = 0; ey = 0;
          cand_cnt = 0; spr_cycles = 0; cpr_cycles = 0; addr_err = 0;
        end
        if (int'(cpr_row) != cpr_cycles) addr_err++;
        cpr_cycles++;
      end
      if (en_spr) begin
        if (int'(spr_col) != ex || int'(spr_row) != ey + rows) addr_err++;
        spr_cycles++;
        rows++;
        if (rows == MD) begin
          rows     = 0;
          dly      = dly_cfg;
          pend_sad = sad_of(ex, ey);
          cand_cnt++;
          if (ex == NP - 1) begin
            ex = 0;
            ey++;
          end else begin
            ex++;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_result(input int sad, input int x, input int y);
    result_t r;
    r.sad = 16'(sad);
    r.x   = 6'(x);
    r.y   = 6'(y);
    sb.push_back(r);
  endtask

  task automatic check_result(input string tag);
    result_t r;
    r = sb.pop_front();
    check({tag, "_min_sad"}, 32'(min_sad), 32'(r.sad));
    check({tag, "_mv_x"}, 32'(mv_x), 32'(r.x));
    check({tag, "_mv_y"}, 32'(mv_y), 32'(r.y));
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_en_spr", 32'(en_spr), 0);
    check("rst_en_cpr", 32'(en_cpr), 0);
    check("rst_min_sad", 32'(min_sad), 32'hFFFF);
    check("rst_mv", {26'd0, mv_x} | {26'd0, mv_y}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // constant SAD, D=3, with a start pulse mid-search
    mode = 0; dly_cfg = 3;
    expect_result(500, 0, 0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("a_busy", 32'(busy), 1);
    repeat (200) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(30000, seen);
    check("a_done_seen", 32'(seen), 1);
    check("a_done_busy", 32'(busy), 0);
    check_result("a");
    check("a_spr_cycles", 32'(spr_cycles), 16 * 1089);
    check("a_cand_cnt", 32'(cand_cnt), 1089);
    check("a_cpr_cycles", 32'(cpr_cycles), 16);
    check("a_addr_err", 32'(addr_err), 0);

    // start in the DONE cycle is ignored, held into the following IDLE cycle it is accepted
    mode = 1; dly_cfg = 1;
    expect_result(100, 17, 5);
    start = 1'b1; @(negedge clk);
    check("done_cycle_start_busy", 32'(busy), 0);
    check("min_sad_held", 32'(min_sad), 500);
    check("a_done_cnt", 32'(done_cnt), 1);
    @(negedge clk); start = 1'b0;
    check("b_busy", 32'(busy), 1);
    wait_done(25000, seen);
    check("b_done_seen", 32'(seen), 1);
    check_result("b");
    check("b_cand_cnt", 32'(cand_cnt), 1089);
    check("b_addr_err", 32'(addr_err), 0);
    @(negedge clk);
    check("b_done_cnt", 32'(done_cnt), 2);

    // abort by reset at candidate 400
    mode = 2; dly_cfg = 3;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (100) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < 10000 && cand_cnt < 400; i++) @(negedge clk);
    check("c_reached_400", 32'(cand_cnt >= 400), 1);
    check("c_cpr_cycles", 32'(cpr_cycles), 16);
    rst_n = 1'b0;
    #1;
    check("c_rst_busy", 32'(busy), 0);
    check("c_rst_en_spr", 32'(en_spr), 0);
    check("c_rst_min_sad", 32'(min_sad), 32'hFFFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("c_no_done", 32'(done_cnt), 2);
    check("c_idle_busy", 32'(busy), 0);

    // fresh search after the abort: tie keeps the earlier candidate
    mode = 2; dly_cfg = 1;
    expect_result(50, 3, 0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(25000, seen);
    check("d_done_seen", 32'(seen), 1);
    check_result("d");
    check("d_cand_cnt", 32'(cand_cnt), 1089);
    check("d_addr_err", 32'(addr_err), 0);

`ifdef ME_EARLY_EXIT_EN
    @(negedge clk);
    mode = 3; dly_cfg = 2;
    expect_result(0, 2, 1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(5000, seen);
    check("e_done_seen", 32'(seen), 1);
    check_result("e");
    check("e_cand_cnt", 32'(cand_cnt), 36);
    check("e_spr_cycles", 32'(spr_cycles), 36 * 16);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
